// File: rtl/sp_pkg.sv
// Shared types and widths for the SP dispatch block: FSM states, field widths and
// the effective-lane-count helper.
package sp_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_LD   = 3'd2,
        S_WACK = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam int OPC_W         = 6;
    localparam int MOD_W         = 3;
    localparam int REG_W         = 9;
    localparam int PRED_W        = 3;
    localparam int TID_W         = 5;
    localparam int CNT_W         = 8;
    localparam int DATA_W        = 32;
    localparam int WARP_SIZE_DEF = 32;

    // Scalar instructions issue one lane; vector counts are clamped to the warp width.
    function automatic logic [CNT_W-1:0] eff_lanes(input logic si,
                                                   input logic [CNT_W-1:0] cnt,
                                                   input int warp);
        if (si) return CNT_W'(1);
        if (int'(cnt) > warp) return CNT_W'(warp);
        return cnt;
    endfunction

endpackage

// File: rtl/sp_dispatch_wdt.sv
// Ack-wait watchdog: counts consecutive un-acked WACK cycles and flags the last allowed one.
module sp_dispatch_wdt #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic Resetn,
    input  logic count_i,
    output logic expire_o
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign cnt_d    = count_i ? cnt_q + CW'(1) : '0;
    assign expire_o = count_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!Resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/sp_dispatch.sv
// SP issue FSM: per-lane operand read, SP start/ack handshake, writeback forwarding.
// Optional ack watchdog is compiled in with `define SP_DISPATCH_TIMEOUT_EN.
module sp_dispatch
    import sp_pkg::*;
#(
    parameter int WARP_SIZE      = WARP_SIZE_DEF,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              Resetn,
    input  logic              inst_valid,
    output logic              inst_ready,
    input  logic [OPC_W-1:0]  inst_opcode,
    input  logic [MOD_W-1:0]  inst_modifier,
    input  logic [REG_W-1:0]  inst_sa,
    input  logic [REG_W-1:0]  inst_sb,
    input  logic [REG_W-1:0]  inst_sc,
    input  logic [REG_W-1:0]  inst_addr_d,
    input  logic [PRED_W-1:0] inst_sp,
    input  logic [PRED_W-1:0] inst_dp,
    input  logic              inst_si,
    input  logic [CNT_W-1:0]  inst_thread_cnt,
    output logic              rf_re,
    output logic [TID_W-1:0]  rf_tid,
    output logic [REG_W-1:0]  rf_addr_a,
    output logic [REG_W-1:0]  rf_addr_b,
    output logic [REG_W-1:0]  rf_addr_c,
    input  logic [DATA_W-1:0] rf_data_a,
    input  logic [DATA_W-1:0] rf_data_b,
    input  logic [DATA_W-1:0] rf_data_c,
    output logic              sp_ena,
    output logic              sp_clr,
    output logic              sp_start,
    output logic [DATA_W-1:0] sp_rs_a,
    output logic [DATA_W-1:0] sp_rs_b,
    output logic [DATA_W-1:0] sp_rs_c,
    output logic [REG_W-1:0]  sp_addr_d,
    output logic [PRED_W-1:0] sp_Sp,
    output logic [PRED_W-1:0] sp_Dp,
    output logic [MOD_W-1:0]  sp_modifier,
    output logic              sp_Si,
    output logic [OPC_W-1:0]  sp_opcode,
    output logic [CNT_W-1:0]  sp_thread_cnt,
    input  logic [DATA_W-1:0] sp_out,
    input  logic [REG_W-1:0]  sp_des_addr,
    input  logic [PRED_W-1:0] sp_des_pre,
    input  logic [TID_W-1:0]  sp_cnt,
    input  logic              sp_ack,
    input  logic              sp_set_pc_req,
    input  logic              sp_outen,
    output logic              wb_en,
    output logic [TID_W-1:0]  wb_tid,
    output logic [REG_W-1:0]  wb_addr,
    output logic [PRED_W-1:0] wb_pre,
    output logic [DATA_W-1:0] wb_data,
    output logic              done,
    output logic              done_set_pc,
    output logic              err_timeout
);
    state_t            state_q;
    logic              inst_ready_q, rf_re_q, sp_ena_q, sp_clr_q, sp_start_q;
    logic              done_q, done_set_pc_q, pc_flag_q, wb_en_q, si_q;
    logic [TID_W-1:0]  tid_q, wb_tid_q;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [REG_W-1:0]  sa_q, sb_q, sc_q, addr_d_q, wb_addr_q;
    logic [PRED_W-1:0] sp_q, dp_q, wb_pre_q;
    logic [MOD_W-1:0]  mod_q;
    logic [OPC_W-1:0]  opc_q;
    logic [DATA_W-1:0] rs_a_q, rs_b_q, rs_c_q, wb_data_q;
    logic              accept_d, more_lanes_d;

    assign n_d          = eff_lanes(inst_si, inst_thread_cnt, WARP_SIZE);
    assign accept_d     = (state_q == S_IDLE) && inst_valid && inst_ready_q;
    assign more_lanes_d = (CNT_W'(tid_q) + CNT_W'(1)) < n_q;

`ifdef SP_DISPATCH_TIMEOUT_EN
    logic wdt_expire;
    logic err_timeout_q;

    sp_dispatch_wdt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdt (
        .clk     (clk),
        .Resetn  (Resetn),
        .count_i ((state_q == S_WACK) && !sp_ack),
        .expire_o(wdt_expire)
    );

    always_ff @(posedge clk) begin
        if (!Resetn)         err_timeout_q <= 1'b0;
        else if (wdt_expire) err_timeout_q <= 1'b1;
    end

    assign err_timeout = err_timeout_q;
`else
    assign err_timeout = 1'b0;
`endif

    // Registered-output FSM; single-cycle strobes default low each cycle.
    always_ff @(posedge clk) begin
        if (!Resetn) begin
            state_q       <= S_IDLE;
            inst_ready_q  <= 1'b1;
            rf_re_q       <= 1'b0;
            sp_ena_q      <= 1'b0;
            sp_clr_q      <= 1'b0;
            sp_start_q    <= 1'b0;
            done_q        <= 1'b0;
            done_set_pc_q <= 1'b0;
            pc_flag_q     <= 1'b0;
            tid_q         <= '0;
            n_q           <= '0;
            sa_q          <= '0;
            sb_q          <= '0;
            sc_q          <= '0;
            addr_d_q      <= '0;
            sp_q          <= '0;
            dp_q          <= '0;
            mod_q         <= '0;
            opc_q         <= '0;
            si_q          <= 1'b0;
            rs_a_q        <= '0;
            rs_b_q        <= '0;
            rs_c_q        <= '0;
            wb_en_q       <= 1'b0;
            wb_tid_q      <= '0;
            wb_addr_q     <= '0;
            wb_pre_q      <= '0;
            wb_data_q     <= '0;
        end else begin
            rf_re_q       <= 1'b0;
            sp_clr_q      <= 1'b0;
            sp_start_q    <= 1'b0;
            done_q        <= 1'b0;
            done_set_pc_q <= 1'b0;

            wb_en_q <= sp_outen;
            if (sp_outen) begin
                wb_data_q <= sp_out;
                wb_addr_q <= sp_des_addr;
                wb_pre_q  <= sp_des_pre;
                wb_tid_q  <= sp_cnt;
            end

            if ((state_q != S_IDLE) && sp_set_pc_req) pc_flag_q <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (accept_d) begin
                        sa_q         <= inst_sa;
                        sb_q         <= inst_sb;
                        sc_q         <= inst_sc;
                        addr_d_q     <= inst_addr_d;
                        sp_q         <= inst_sp;
                        dp_q         <= inst_dp;
                        mod_q        <= inst_modifier;
                        opc_q        <= inst_opcode;
                        si_q         <= inst_si;
                        n_q          <= n_d;
                        tid_q        <= '0;
                        sp_clr_q     <= 1'b1;
                        sp_ena_q     <= 1'b1;
                        inst_ready_q <= 1'b0;
                        if (n_d == '0) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_RD;
                            rf_re_q <= 1'b1;
                        end
                    end else begin
                        inst_ready_q <= 1'b1;
                    end
                end
                S_RD: begin
                    state_q <= S_LD;
                end
                S_LD: begin
                    rs_a_q     <= rf_data_a;
                    rs_b_q     <= rf_data_b;
                    rs_c_q     <= rf_data_c;
                    sp_start_q <= 1'b1;
                    state_q    <= S_WACK;
                end
                S_WACK: begin
                    if (sp_ack) begin
                        if (more_lanes_d) begin
                            tid_q   <= tid_q + TID_W'(1);
                            rf_re_q <= 1'b1;
                            state_q <= S_RD;
                        end else begin
                            state_q <= S_DONE;
                        end
`ifdef SP_DISPATCH_TIMEOUT_EN
                    end else if (wdt_expire) begin
                        pc_flag_q <= 1'b0;
                        state_q   <= S_DONE;
`endif
                    end
                end
                S_DONE: begin
                    done_q        <= 1'b1;
                    done_set_pc_q <= pc_flag_q;
                    pc_flag_q     <= 1'b0;
                    sp_ena_q      <= 1'b0;
                    state_q       <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign inst_ready    = inst_ready_q;
    assign rf_re         = rf_re_q;
    assign rf_tid        = tid_q;
    assign rf_addr_a     = sa_q;
    assign rf_addr_b     = sb_q;
    assign rf_addr_c     = sc_q;
    assign sp_ena        = sp_ena_q;
    assign sp_clr        = sp_clr_q;
    assign sp_start      = sp_start_q;
    assign sp_rs_a       = rs_a_q;
    assign sp_rs_b       = rs_b_q;
    assign sp_rs_c       = rs_c_q;
    assign sp_addr_d     = addr_d_q;
    assign sp_Sp         = sp_q;
    assign sp_Dp         = dp_q;
    assign sp_modifier   = mod_q;
    assign sp_Si         = si_q;
    assign sp_opcode     = opc_q;
    assign sp_thread_cnt = n_q;
    assign wb_en         = wb_en_q;
    assign wb_tid        = wb_tid_q;
    assign wb_addr       = wb_addr_q;
    assign wb_pre        = wb_pre_q;
    assign wb_data       = wb_data_q;
    assign done          = done_q;
    assign done_set_pc   = done_set_pc_q;

endmodule

// File: tb/tb_sp_dispatch.sv
// Self-checking bench for sp_dispatch: directed table, random instructions against a
// lane/latency model, writeback forwarding, mid-instruction reset, optional watchdog.
`timescale 1ns/1ps
module tb_sp_dispatch;
    logic        clk = 1'b0;
    logic        Resetn;
    logic        inst_valid, inst_ready;
    logic [5:0]  inst_opcode;
    logic [2:0]  inst_modifier;
    logic [8:0]  inst_sa, inst_sb, inst_sc, inst_addr_d;
    logic [2:0]  inst_sp, inst_dp;
    logic        inst_si;
    logic [7:0]  inst_thread_cnt;
    logic        rf_re;
    logic [4:0]  rf_tid;
    logic [8:0]  rf_addr_a, rf_addr_b, rf_addr_c;
    logic [31:0] rf_data_a, rf_data_b, rf_data_c;
    logic        sp_ena, sp_clr, sp_start;
    logic [31:0] sp_rs_a, sp_rs_b, sp_rs_c;
    logic [8:0]  sp_addr_d;
    logic [2:0]  sp_Sp, sp_Dp, sp_modifier;
    logic        sp_Si;
    logic [5:0]  sp_opcode;
    logic [7:0]  sp_thread_cnt;
    logic [31:0] sp_out;
    logic [8:0]  sp_des_addr;
    logic [2:0]  sp_des_pre;
    logic [4:0]  sp_cnt;
    logic        sp_ack, sp_set_pc_req, sp_outen;
    logic        wb_en;
    logic [4:0]  wb_tid;
    logic [8:0]  wb_addr;
    logic [2:0]  wb_pre;
    logic [31:0] wb_data;
    logic        done, done_set_pc, err_timeout;

    always #5 clk = ~clk;

    sp_dispatch #(.WARP_SIZE(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .Resetn(Resetn),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_opcode(inst_opcode), .inst_modifier(inst_modifier),
        .inst_sa(inst_sa), .inst_sb(inst_sb), .inst_sc(inst_sc), .inst_addr_d(inst_addr_d),
        .inst_sp(inst_sp), .inst_dp(inst_dp), .inst_si(inst_si), .inst_thread_cnt(inst_thread_cnt),
        .rf_re(rf_re), .rf_tid(rf_tid),
        .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b), .rf_addr_c(rf_addr_c),
        .rf_data_a(rf_data_a), .rf_data_b(rf_data_b), .rf_data_c(rf_data_c),
        .sp_ena(sp_ena), .sp_clr(sp_clr), .sp_start(sp_start),
        .sp_rs_a(sp_rs_a), .sp_rs_b(sp_rs_b), .sp_rs_c(sp_rs_c),
        .sp_addr_d(sp_addr_d), .sp_Sp(sp_Sp), .sp_Dp(sp_Dp), .sp_modifier(sp_modifier),
        .sp_Si(sp_Si), .sp_opcode(sp_opcode), .sp_thread_cnt(sp_thread_cnt),
        .sp_out(sp_out), .sp_des_addr(sp_des_addr), .sp_des_pre(sp_des_pre), .sp_cnt(sp_cnt),
        .sp_ack(sp_ack), .sp_set_pc_req(sp_set_pc_req), .sp_outen(sp_outen),
        .wb_en(wb_en), .wb_tid(wb_tid), .wb_addr(wb_addr), .wb_pre(wb_pre), .wb_data(wb_data),
        .done(done), .done_set_pc(done_set_pc), .err_timeout(err_timeout)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      nm;
        logic       si;
        logic [7:0] cnt;
        int         dly;
        int         pc_lane;
        int         exp_n;
        int         exp_lat;
        logic       exp_pc;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Register-file contents as a function of lane, address and port.
    function automatic logic [31:0] opnd(input int port, input int tid, input logic [8:0] addr);
        return (32'(addr) * 32'h0001_0003) ^ (32'(tid) << 20) ^ (32'(port) << 29);
    endfunction

    task automatic run_inst(input string nm, input logic si, input logic [7:0] cnt, input int dly,
                            input int pc_lane, input int exp_n, input int exp_lat, input logic exp_pc);
        logic [8:0]  sa, sb, sc, ad, pa, pb, pcc;
        logic [5:0]  opc;
        logic [4:0]  pend_tid, wb_exp_tid;
        logic [31:0] ea, eb, ec, wb_exp;
        logic        saw_dpc;
        int          c, lane, starts, reads, wcnt, done_c;
        bit          pend, wb_pend, waiting, tid_ok, addr_ok, op_ok, hold_ok, wb_ok, ready_ok;
        sa = 9'($urandom); sb = 9'($urandom); sc = 9'($urandom); ad = 9'($urandom);
        opc = 6'($urandom);
        inst_sa = sa; inst_sb = sb; inst_sc = sc; inst_addr_d = ad;
        inst_opcode = opc; inst_modifier = 3'($urandom);
        inst_sp = 3'($urandom); inst_dp = 3'($urandom);
        inst_si = si; inst_thread_cnt = cnt;
        inst_valid = 1'b1;
        chk({nm, ".ready_in"}, 32'(inst_ready), 32'd1);
        tick();
        inst_valid = 1'b0;
        c = 1; lane = 0; starts = 0; reads = 0; wcnt = 0; done_c = -1;
        pend = 0; wb_pend = 0; waiting = 0; saw_dpc = 1'b0;
        tid_ok = 1; addr_ok = 1; op_ok = 1; hold_ok = 1; wb_ok = 1; ready_ok = 1;
        ea = '0; eb = '0; ec = '0; wb_exp = '0; wb_exp_tid = '0;
        pa = '0; pb = '0; pcc = '0; pend_tid = '0;
        while (c < 700) begin
            sp_ack = 1'b0; sp_set_pc_req = 1'b0; sp_outen = 1'b0;
            if (pend) begin
                rf_data_a = opnd(0, int'(pend_tid), pa);
                rf_data_b = opnd(1, int'(pend_tid), pb);
                rf_data_c = opnd(2, int'(pend_tid), pcc);
                pend = 0;
            end
            if (wb_pend) begin
                if (!(wb_en === 1'b1 && wb_data === wb_exp && wb_tid === wb_exp_tid && wb_addr === ad))
                    wb_ok = 0;
                wb_pend = 0;
            end
            if (rf_re) begin
                if (rf_tid !== 5'(reads)) tid_ok = 0;
                if (rf_addr_a !== sa || rf_addr_b !== sb || rf_addr_c !== sc) addr_ok = 0;
                pend = 1; pend_tid = rf_tid;
                pa = rf_addr_a; pb = rf_addr_b; pcc = rf_addr_c;
                reads++;
            end
            if (sp_start) begin
                starts++;
                ea = opnd(0, lane, sa); eb = opnd(1, lane, sb); ec = opnd(2, lane, sc);
                if (sp_rs_a !== ea || sp_rs_b !== eb || sp_rs_c !== ec) op_ok = 0;
                waiting = 1; wcnt = 0;
            end else if (waiting && (sp_rs_a !== ea || sp_rs_b !== eb || sp_rs_c !== ec)) begin
                hold_ok = 0;
            end
            if (waiting) begin
                if (sp_opcode !== opc || sp_addr_d !== ad || sp_ena !== 1'b1) hold_ok = 0;
                if (wcnt == dly) begin
                    sp_ack = 1'b1;
                    sp_outen = 1'b1;
                    sp_out = ea ^ 32'hA5A5_0000;
                    sp_des_addr = ad; sp_des_pre = 3'($urandom); sp_cnt = 5'(lane);
                    wb_exp = ea ^ 32'hA5A5_0000; wb_exp_tid = 5'(lane); wb_pend = 1;
                    if (lane == pc_lane) sp_set_pc_req = 1'b1;
                    waiting = 0;
                    lane++;
                end
                wcnt++;
            end
            if (done) begin
                done_c = c;
                saw_dpc = done_set_pc;
                if (inst_ready !== 1'b0) ready_ok = 0;
                break;
            end
            if (inst_ready !== 1'b0) ready_ok = 0;
            tick();
            c++;
        end
        sp_ack = 1'b0; sp_set_pc_req = 1'b0; sp_outen = 1'b0;
        chk({nm, ".done_cycle"}, 32'(done_c), 32'(exp_lat));
        chk({nm, ".starts"}, 32'(starts), 32'(exp_n));
        chk({nm, ".reads"}, 32'(reads), 32'(exp_n));
        chk({nm, ".rf_tid_seq"}, 32'(tid_ok), 32'd1);
        chk({nm, ".rf_addr"}, 32'(addr_ok), 32'd1);
        chk({nm, ".operands"}, 32'(op_ok), 32'd1);
        chk({nm, ".hold_stable"}, 32'(hold_ok), 32'd1);
        chk({nm, ".writeback"}, 32'(wb_ok), 32'd1);
        chk({nm, ".ready_low"}, 32'(ready_ok), 32'd1);
        chk({nm, ".done_set_pc"}, 32'(saw_dpc), 32'(exp_pc));
        tick();
        chk({nm, ".done_pulse"}, 32'(done), 32'd0);
        chk({nm, ".ready_back"}, 32'(inst_ready), 32'd1);
    endtask

    vec_t tbl[5];

    initial begin
        vec_t        v;
        int          n, guard;
        tbl[0] = '{"n4",     1'b0, 8'd4,   0, -1, 4,  14, 1'b0};
        tbl[1] = '{"scalar", 1'b1, 8'd20,  0, -1, 1,  5,  1'b0};
        tbl[2] = '{"clamp",  1'b0, 8'd200, 0, -1, 32, 98, 1'b0};
        tbl[3] = '{"zero",   1'b0, 8'd0,   0, -1, 0,  2,  1'b0};
        tbl[4] = '{"delay7", 1'b0, 8'd3,   7, 1,  3,  32, 1'b1};

        Resetn = 1'b0; inst_valid = 1'b0; inst_opcode = '0; inst_modifier = '0;
        inst_sa = '0; inst_sb = '0; inst_sc = '0; inst_addr_d = '0; inst_sp = '0; inst_dp = '0;
        inst_si = 1'b0; inst_thread_cnt = '0;
        rf_data_a = '0; rf_data_b = '0; rf_data_c = '0;
        sp_out = '0; sp_des_addr = '0; sp_des_pre = '0; sp_cnt = '0;
        sp_ack = 1'b0; sp_set_pc_req = 1'b0; sp_outen = 1'b0;
        tick(); tick();
        chk("rst.inst_ready", 32'(inst_ready), 32'd1);
        chk("rst.strobes", {25'd0, rf_re, sp_ena, sp_clr, sp_start, wb_en, done, done_set_pc}, 32'd0);
        chk("rst.err_timeout", 32'(err_timeout), 32'd0);
        chk("rst.sp_rs_a", sp_rs_a, 32'd0);
        chk("rst.wb_data", wb_data, 32'd0);
        Resetn = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            v = tbl[i];
            run_inst(v.nm, v.si, v.cnt, v.dly, v.pc_lane, v.exp_n, v.exp_lat, v.exp_pc);
        end

        // Randomized instructions checked against the lane-count/latency model.
        for (int i = 0; i < 8; i++) begin
            logic       si;
            logic [7:0] cnt;
            int         dly, pcl;
            si  = ($urandom_range(0, 3) == 0);
            cnt = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(33, 255)) : 8'($urandom_range(0, 12));
            dly = $urandom_range(0, 3);
            pcl = $urandom_range(0, 5) - 1;
            n   = si ? 1 : ((int'(cnt) > 32) ? 32 : int'(cnt));
            run_inst($sformatf("rnd%0d", i), si, cnt, dly, pcl, n, n * (3 + dly) + 2,
                     (pcl >= 0 && pcl < n));
        end

        // Writeback forwarding with no instruction in flight.
        sp_outen = 1'b1; sp_out = 32'hDEAD_BEEF; sp_des_addr = 9'h1A0; sp_des_pre = 3'd5; sp_cnt = 5'd9;
        tick();
        sp_outen = 1'b0;
        chk("wb.en", 32'(wb_en), 32'd1);
        chk("wb.data", wb_data, 32'hDEAD_BEEF);
        chk("wb.addr", 32'(wb_addr), 32'h1A0);
        chk("wb.pre_tid", {24'd0, wb_pre, wb_tid}, {24'd0, 3'd5, 5'd9});
        tick();
        chk("wb.en_drop", 32'(wb_en), 32'd0);

        // Reset while waiting for ack aborts the instruction silently.
        inst_si = 1'b0; inst_thread_cnt = 8'd4; inst_sa = 9'h011; inst_valid = 1'b1;
        tick();
        inst_valid = 1'b0;
        guard = 0;
        while (!sp_start && guard < 10) begin tick(); guard++; end
        chk("abort.reached_wack", 32'(sp_start), 32'd1);
        tick(); tick();
        Resetn = 1'b0;
        tick();
        Resetn = 1'b1;
        chk("abort.inst_ready", 32'(inst_ready), 32'd1);
        chk("abort.strobes", {26'd0, rf_re, sp_ena, sp_clr, sp_start, done, done_set_pc}, 32'd0);
        chk("abort.sp_rs_a", sp_rs_a, 32'd0);
        guard = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done || sp_start || sp_ena) guard++;
        end
        chk("abort.quiet", 32'(guard), 32'd0);

`ifdef SP_DISPATCH_TIMEOUT_EN
        begin
            int s, d;
            inst_si = 1'b0; inst_thread_cnt = 8'd2; inst_valid = 1'b1;
            tick();
            inst_valid = 1'b0;
            guard = 0;
            while (!sp_start && guard < 10) begin tick(); guard++; end
            sp_set_pc_req = 1'b1;
            s = 0; d = -1;
            while (s < 40) begin
                if (done) begin d = s; break; end
                tick();
                sp_set_pc_req = 1'b0;
                s++;
            end
            chk("wdt.done_cycle", 32'(d), 32'd17);
            chk("wdt.done_set_pc", 32'(done_set_pc), 32'd0);
            chk("wdt.err_timeout", 32'(err_timeout), 32'd1);
            tick();
            chk("wdt.err_sticky", 32'(err_timeout), 32'd1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/sp_dispatch.md
# sp_dispatch

Issue-side initiator for the streaming processor (SP): accepts one decoded instruction from the warp scheduler, reads per-thread operands from the register file, and drives the SP `start`/`ack` handshake once per active thread. It also forwards SP result writes to the register-file writeback port and reports completion, including any PC-set request, back to the scheduler.

## Interface
- `WARP_SIZE`, 32: maximum lanes per instruction; `thread_cnt` is clamped to this value.
- `TIMEOUT_CYCLES`, 1024: watchdog limit; used only when the timeout feature is compiled in.
- `clk`  in  1  sole clock; all logic is rising-edge.
- `Resetn`  in  1  reset; synchronous, active-low.
- `inst_valid` / `inst_ready`  in / out  1 / 1  instruction handshake.
- `inst_opcode`  in  6  opcode.
- `inst_modifier`  in  3  modifier.
- `inst_sa`, `inst_sb`, `inst_sc`  in  9 each  source register indices.
- `inst_addr_d`  in  9  destination register index.
- `inst_sp`, `inst_dp`  in  3 each  source and destination predicates.
- `inst_si`  in  1  scalar instruction; issue lane 0 only.
- `inst_thread_cnt`  in  8  active lane count.
- `rf_re`  out  1  register-file read enable.
- `rf_tid`  out  5  lane being read.
- `rf_addr_a/b/c`  out  9 each  register-file read addresses.
- `rf_data_a/b/c`  in  32 each  read data; valid exactly one cycle after `rf_re`.
- `sp_ena`  out  1  SP enable.
- `sp_clr`  out  1  SP clear.
- `sp_start`  out  1  SP start.
- `sp_rs_a/b/c`  out  32 each  operands to the SP.
- `sp_addr_d`  out  9  destination index to the SP.
- `sp_Sp`, `sp_Dp`  out  3 each  predicates to the SP.
- `sp_modifier`  out  3  modifier to the SP.
- `sp_Si`  out  1  scalar flag to the SP.
- `sp_opcode`  out  6  opcode to the SP.
- `sp_thread_cnt`  out  8  lane count to the SP.
- `sp_out`  in  32  SP result data.
- `sp_des_addr`  in  9  SP result destination.
- `sp_des_pre`  in  3  SP result predicate.
- `sp_cnt`  in  5  lane index of the SP result.
- `sp_ack`  in  1  SP lane-complete acknowledge.
- `sp_set_pc_req`  in  1  SP request to set the PC.
- `sp_outen`  in  1  SP result valid.
- `wb_en`  out  1  writeback enable.
- `wb_tid`  out  5  writeback lane.
- `wb_addr`  out  9  writeback register index.
- `wb_pre`  out  3  writeback predicate.
- `wb_data`  out  32  writeback data.
- `done`  out  1  one-cycle instruction-complete pulse.
- `done_set_pc`  out  1  qualifies `done`: a PC-set request was seen.
- `err_timeout`  out  1  sticky watchdog error.

## Operation
- Effective lane count `n`:
  - `inst_si` set: n = 1.
  - Otherwise: n = min(`inst_thread_cnt`, WARP_SIZE).
  - n = 0: skip straight to DONE; no SP traffic.
- FSM states: IDLE, RD, LD, WACK, DONE.
- IDLE
  - `inst_ready`=1.
  - On accept: latch all instruction fields, set tid=0, pulse `sp_clr` for one cycle.
  - Go to RD, or to DONE if n=0.
- RD
  - `rf_re`=1 for one cycle; `rf_tid`=tid; `rf_addr_*`=`inst_s*`.
  - Go to LD.
- LD
  - Register `rf_data_*` into `sp_rs_*` and set `sp_start` at the same edge.
  - Go to WACK.
- WACK
  - `sp_start` is high only in the first WACK cycle.
  - `sp_rs_*` and the other `sp_*` fields stay stable until `sp_ack`.
  - On `sp_ack`: if tid+1 < n, tid++ and go to RD; else go to DONE.
  - `sp_ack` in any other state is ignored.
- DONE
  - `done`=1 and `done_set_pc`=latched set-PC flag for one cycle.
  - Clear the set-PC flag; go to IDLE.
- `sp_ena`=1 in every state except IDLE.
- Set-PC flag is set by `sp_set_pc_req` in any non-IDLE state.
- Writeback forwarding is independent of the FSM:
  - When `sp_outen`=1, the next cycle shows `wb_en`=1 with `wb_data`=`sp_out`, `wb_addr`=`sp_des_addr`, `wb_pre`=`sp_des_pre`, `wb_tid`=`sp_cnt`.
- tid is 5 bits; it never wraps, because n ≤ 32 guarantees the last lane index is 31.

## Timing
- Reset values: all outputs 0 except `inst_ready`=1; state=IDLE.
- Reset asserted mid-instruction aborts the instruction with no `done`.
- Lane cadence: RD → LD → WACK.
  - `sp_start` rises 2 cycles after entering RD.
  - Minimum 3 cycles per lane with a same-cycle ack.
- Cycles from accept to `done` (same-cycle acks): 3n+2.
  - n=0: `done` 2 cycles after accept.
- `inst_ready` is low from the cycle after accept through DONE.
  - Next accept is possible at the earliest the cycle after `done`.
- `sp_outen` coincident with `sp_ack`: both are honoured in the same cycle.

## Configuration
- `SP_DISPATCH_TIMEOUT_EN` defined:
  - A watchdog counts cycles spent in WACK.
  - Reaching TIMEOUT_CYCLES sets `err_timeout` (sticky until reset) and forces DONE with `done_set_pc`=0.
- Undefined: no counter; `err_timeout` tied to 0; WACK waits indefinitely.

## Structure
- `sp_pkg` holds:
  - FSM state enum.
  - Opcode, register-index and predicate width constants.
  - Default WARP_SIZE.
- Sub-module `sp_dispatch_wdt` holds the watchdog counter; it is instantiated only under the macro.

## Test plan
- n=4, SP acks on the first WACK cycle → exactly 4 `sp_start` pulses, `rf_tid` 0,1,2,3; `done` at cycle 14 after accept.
- `inst_si`=1, `inst_thread_cnt`=20 → exactly one lane issued (tid 0); `done` at cycle 5.
- `inst_thread_cnt`=200 → 32 lanes issued; last `rf_tid`=31; no wrap.
- `inst_thread_cnt`=0 → no `rf_re`, no `sp_start`; `done` 2 cycles after accept.
- Ack delayed 7 cycles; `sp_set_pc_req` on lane 1 → operands held stable throughout the wait; `done_set_pc`=1; `sp_outen` data 0xDEADBEEF at dest 0x1A0 → `wb_data`/`wb_addr` appear one cycle later.
- `Resetn` low during WACK, then ack never sent → all outputs return to reset values, no `done`; with `SP_DISPATCH_TIMEOUT_EN` and TIMEOUT_CYCLES=16 → `err_timeout`=1 and `done` after 16 WACK cycles.
